// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0), MSB-first responder running on clk_100.
// The external pins are oversampled through synchronizers, and edges are found by
// comparing the last synchronizer stage with one more flop.
//
// Ports:
//   clk_100, a_rst_n (async, active low), s_rst (sync, active high clear)
//   sck_in, cs_n_in, mosi_in : asynchronous SPI pins
//   miso_out                 : serial data out, 0 when not selected
//   tx_data/tx_valid/tx_ready: one-entry holding register. A word is taken on the
//                              cycle where tx_valid && tx_ready.
//   rx_data/rx_valid         : last complete word, plus a one-cycle strobe on update
//   busy                     : high while the frame is active
//   tx_underrun              : pulse, a word load found the holding register empty
//   frame_err                : pulse, chip select released mid-word
module spi_slave #(
  parameter int P_DATA_W      = 8,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic                clk_100,
  input  logic                a_rst_n,
  input  logic                s_rst,
  input  logic                sck_in,
  input  logic                cs_n_in,
  input  logic                mosi_in,
  output logic                miso_out,
  input  logic [P_DATA_W-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [P_DATA_W-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                tx_underrun,
  output logic                frame_err
);

  localparam int CW = $clog2(P_DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(P_DATA_W - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [P_SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                     sck_d, cs_d;
  // Fills with ones after reset. Until it is full, the cs_n history is the reset value
  // and not the pin.
  logic [P_SYNC_STAGES:0]   fill;
  // Set once cs_n has genuinely been seen high. This stops a frame that was already
  // running across a reset from being taken as a new cs_fall.
  logic                     armed;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  state_t              state;
  logic [CW-1:0]       bit_cnt;
  logic [P_DATA_W-1:0] rx_shift, tx_shift, hold;
  logic                hold_full, pending_load;
  logic                load, hs, shift_en;

  assign sck_s  = sck_sync[P_SYNC_STAGES-1];
  assign cs_s   = cs_sync[P_SYNC_STAGES-1];
  assign mosi_s = mosi_sync[P_SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = armed & cs_d & ~cs_s;
  assign cs_rise  = cs_s & ~cs_d;

  assign tx_ready = ~hold_full;
  assign busy     = (state == ST_ACTIVE);
  assign hs       = tx_valid & ~hold_full;

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    if (state == ST_IDLE) begin
      load = cs_fall;
    end else if (!cs_rise && sck_fall) begin
      load     = pending_load;
      shift_en = ~pending_load;
    end
  end

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
    end else if (s_rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[P_SYNC_STAGES-2:0], sck_in};
      mosi_sync <= {mosi_sync[P_SYNC_STAGES-2:0], mosi_in};
      cs_sync   <= {cs_sync[P_SYNC_STAGES-2:0], cs_n_in};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      fill      <= {fill[P_SYNC_STAGES-1:0], 1'b1};
      if (fill[P_SYNC_STAGES] && cs_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      pending_load <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_underrun  <= 1'b0;
      frame_err    <= 1'b0;
      miso_out     <= 1'b0;
    end else if (s_rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      pending_load <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_underrun  <= 1'b0;
      frame_err    <= 1'b0;
      miso_out     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;

      // The load sees the state from before this cycle. So a handshake in the same
      // cycle as a load still counts as an underrun, and it refills the register for
      // the next load.
      if (hs) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        tx_shift    <= hold_full ? hold : '0;
        tx_underrun <= ~hold_full;
      end else if (shift_en) begin
        tx_shift <= {tx_shift[P_DATA_W-2:0], 1'b0};
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state        <= ST_ACTIVE;
            bit_cnt      <= '0;
            pending_load <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            // A pending load is dropped here, so the holding register is not consumed.
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            pending_load <= 1'b0;
            frame_err    <= (bit_cnt != '0);
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[P_DATA_W-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
              rx_data      <= {rx_shift[P_DATA_W-2:0], mosi_s};
              rx_valid     <= 1'b1;
              bit_cnt      <= '0;
              pending_load <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall && pending_load) begin
            pending_load <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      miso_out <= (state == ST_ACTIVE) ? tx_shift[P_DATA_W-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave. It runs an SPI master model with sck = clk_100/8, and a
// word-level model of expected RX words. It checks frames, the holding register,
// error pulses and both resets.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int SYNC = 2;

  // Clock and reset
  logic clk_100 = 1'b0;
  logic a_rst_n = 1'b0;
  logic s_rst   = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic         sck_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0;
  logic         miso_out;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, busy, tx_underrun, frame_err;

  spi_slave #(.P_DATA_W(W), .P_SYNC_STAGES(SYNC)) dut (
    .clk_100    (clk_100),
    .a_rst_n    (a_rst_n),
    .s_rst      (s_rst),
    .sck_in     (sck_in),
    .cs_n_in    (cs_n_in),
    .mosi_in    (mosi_in),
    .miso_out   (miso_out),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .tx_underrun(tx_underrun),
    .frame_err  (frame_err)
  );

  int total = 0;
  int bad   = 0;
  int n_rx = 0, n_under = 0, n_ferr = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_rx = '0;
  logic         s_rst_seen = 1'b0;

  always @(posedge clk_100) s_rst_seen <= s_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard. Every rx_valid pops the next expected word. Between pulses,
  // rx_data must hold the last word (0 after any reset).
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk_100);
      if (!a_rst_n || s_rst_seen) model_rx = '0;
      if (rx_valid) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got 0x%0h with no word expected", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", rx_data, e);
          model_rx = e;
        end
      end else begin
        check("rx_hold", rx_data, model_rx);
      end
      n_under += int'(tx_underrun);
      n_ferr  += int'(frame_err);
    end
  end

  // Driver tasks
  task automatic tx_write(input logic [W-1:0] d);
    int n = 0;
    @(negedge clk_100);
    while (!tx_ready && n < 100) begin
      @(negedge clk_100);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_100);
    tx_valid = 1'b0;
  endtask

  task automatic clock_bit(input logic b, output logic m);
    mosi_in = b;
    repeat (4) @(negedge clk_100);
    m = miso_out;
    sck_in = 1'b1;
    repeat (4) @(negedge clk_100);
    sck_in = 1'b0;
  endtask

  // One chip-select frame of nw words. The last word has last_bits bits. The final
  // sck fall and the cs_n release happen together.
  task automatic spi_frame(input logic [W-1:0] m0, input logic [W-1:0] m1, input int nw,
                           input int last_bits, input logic hs_load, input logic [W-1:0] hs_d,
                           input logic wr_mid, input logic [W-1:0] wr_d,
                           output logic [W-1:0] s0, output logic [W-1:0] s1);
    logic [W-1:0] word, cap;
    int bits;
    s0 = '0;
    s1 = '0;
    @(negedge clk_100);
    cs_n_in = 1'b0;
    repeat (SYNC) @(negedge clk_100);
    if (hs_load) begin
      check("ready_at_load", tx_ready, 1);
      tx_data  = hs_d;
      tx_valid = 1'b1;
    end
    @(negedge clk_100);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk_100);
    for (int w = 0; w < nw; w++) begin
      word = (w == 0) ? m0 : m1;
      bits = (w == nw - 1) ? last_bits : W;
      cap  = '0;
      for (int b = 0; b < bits; b++) begin
        mosi_in = word[W-1-b];
        repeat (4) @(negedge clk_100);
        cap = {cap[W-2:0], miso_out};
        if (w == 0 && b == 0) begin
          check("busy_in_frame", busy, 1);
          check("ready_after_load", tx_ready, hs_load ? 0 : 1);
        end
        sck_in = 1'b1;
        if (wr_mid && w == 0 && b == 3) begin
          check("ready_mid", tx_ready, 1);
          tx_data  = wr_d;
          tx_valid = 1'b1;
          @(negedge clk_100);
          tx_valid = 1'b0;
          repeat (3) @(negedge clk_100);
        end else begin
          repeat (4) @(negedge clk_100);
        end
        sck_in = 1'b0;
        if (w == nw - 1 && b == bits - 1) cs_n_in = 1'b1;
      end
      if (w == 0) s0 = cap;
      else        s1 = cap;
    end
    mosi_in = 1'b0;
    repeat (12) @(negedge clk_100);
    check("busy_after_frame", busy, 0);
    check("rx_queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, miso_out, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_underrun"}, tx_underrun, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] s0, s1;
    logic m;
    int r0, u0, f0;

    #12;
    check_reset_outputs("por");
    @(negedge clk_100);
    a_rst_n = 1'b1;
    repeat (10) @(negedge clk_100);

    // One word, preloaded 0x3C, master sends 0xA5
    tx_write(8'h3C);
    exp_q.push_back(8'hA5);
    r0 = n_rx; u0 = n_under; f0 = n_ferr;
    spi_frame(8'hA5, 8'h00, 1, 8, 1'b0, 8'h00, 1'b0, 8'h00, s0, s1);
    check("t1_miso", s0, 8'h3C);
    check("t1_rx_count", n_rx - r0, 1);
    check("t1_underrun", n_under - u0, 0);
    check("t1_ferr", n_ferr - f0, 0);
    check("t1_rx_data", rx_data, 8'hA5);

    // Two words in one frame. The second TX word is written during the first word.
    tx_write(8'h81);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    r0 = n_rx; u0 = n_under; f0 = n_ferr;
    spi_frame(8'h12, 8'h34, 2, 8, 1'b0, 8'h00, 1'b1, 8'h7E, s0, s1);
    check("t2_miso0", s0, 8'h81);
    check("t2_miso1", s1, 8'h7E);
    check("t2_rx_count", n_rx - r0, 2);
    check("t2_underrun", n_under - u0, 0);

    // Empty holding register at cs_fall
    exp_q.push_back(8'hC3);
    r0 = n_rx; u0 = n_under; f0 = n_ferr;
    spi_frame(8'hC3, 8'h00, 1, 8, 1'b0, 8'h00, 1'b0, 8'h00, s0, s1);
    check("t3_miso", s0, 8'h00);
    check("t3_rx_count", n_rx - r0, 1);
    check("t3_underrun", n_under - u0, 1);

    // Handshake in the exact cycle of the cs_fall load
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    r0 = n_rx; u0 = n_under; f0 = n_ferr;
    spi_frame(8'h55, 8'hAA, 2, 8, 1'b1, 8'h96, 1'b0, 8'h00, s0, s1);
    check("t4_miso0", s0, 8'h00);
    check("t4_miso1", s1, 8'h96);
    check("t4_underrun", n_under - u0, 1);
    check("t4_rx_count", n_rx - r0, 2);

    // Chip select released after 3 bits, then a good frame
    tx_write(8'h99);
    r0 = n_rx; u0 = n_under; f0 = n_ferr;
    spi_frame(8'hE0, 8'h00, 1, 3, 1'b0, 8'h00, 1'b0, 8'h00, s0, s1);
    check("t5_partial_miso", s0, 8'h04);
    check("t5_ferr", n_ferr - f0, 1);
    check("t5_rx_count", n_rx - r0, 0);
    check("t5_rx_kept", rx_data, 8'hAA);
    check("t5_underrun", n_under - u0, 0);
    tx_write(8'h66);
    exp_q.push_back(8'h5A);
    r0 = n_rx;
    spi_frame(8'h5A, 8'h00, 1, 8, 1'b0, 8'h00, 1'b0, 8'h00, s0, s1);
    check("t5b_miso", s0, 8'h66);
    check("t5b_rx_count", n_rx - r0, 1);

    // Async reset mid-word. The master keeps clocking and must be ignored.
    r0 = n_rx; u0 = n_under; f0 = n_ferr;
    tx_write(8'h11);
    @(negedge clk_100);
    cs_n_in = 1'b0;
    repeat (8) @(negedge clk_100);
    tx_write(8'h22);
    check("t6_ready_full", tx_ready, 0);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, m);
    check("t6_busy_pre", busy, 1);
    #2 a_rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk_100);
    @(negedge clk_100);
    #2 a_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) clock_bit(1'b1, m);
    check("t6_busy_ignored", busy, 0);
    cs_n_in = 1'b1;
    repeat (12) @(negedge clk_100);
    check("t6_rx_count", n_rx - r0, 0);
    check("t6_underrun", n_under - u0, 0);
    check("t6_ferr", n_ferr - f0, 0);

    // Sync reset mid-word
    tx_write(8'h33);
    @(negedge clk_100);
    cs_n_in = 1'b0;
    repeat (8) @(negedge clk_100);
    tx_write(8'h44);
    for (int i = 0; i < 3; i++) clock_bit(1'b0, m);
    check("t7_busy_pre", busy, 1);
    #2 s_rst = 1'b1;
    @(negedge clk_100);
    #1 check_reset_outputs("srst");
    #1 s_rst = 1'b0;
    for (int i = 0; i < 5; i++) clock_bit(1'b1, m);
    check("t7_busy_ignored", busy, 0);
    cs_n_in = 1'b1;
    repeat (12) @(negedge clk_100);
    check("t7_rx_count", n_rx - r0, 0);
    check("t7_underrun", n_under - u0, 0);
    check("t7_ferr", n_ferr - f0, 0);

    // A clean frame after both resets
    tx_write(8'hF0);
    exp_q.push_back(8'hF0);
    r0 = n_rx; u0 = n_under;
    spi_frame(8'hF0, 8'h00, 1, 8, 1'b0, 8'h00, 1'b0, 8'h00, s0, s1);
    check("t8_miso", s0, 8'hF0);
    check("t8_rx_count", n_rx - r0, 1);
    check("t8_underrun", n_under - u0, 0);
    check("t8_rx_data", rx_data, 8'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
